lane_serializer: RTL and testbench

- Parallel-to-serial pattern emitter that feeds the serial input of the game-lane shift register.
- Accepts a W-bit spawn pattern over a valid/ready handshake.
- On each game tick, emits one bit in the order matching the lane's shift direction, then a fixed run of empty bits.
- Sits between the level/spawn controller and the lane register.

---
 rtl/lane_serializer.sv | 151 +++++++++++++++
 tb/tb_lane_serializer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/lane_serializer.sv
// Parallel-to-serial spawn pattern emitter feeding a game-lane shift register.
// Optional LFSR auto-spawn in IDLE is enabled by defining LFSR_AUTO_EN.
module lane_serializer #(
  parameter int          W         = 5,
  parameter int          GAP_TICKS = 2,
  parameter logic [7:0]  SEED      = 8'hA5
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         tick,
  input  logic         abort,
  input  logic         dir,
  input  logic         pat_valid,
  input  logic [W-1:0] pat_data,
  output logic         pat_ready,
  output logic         serial,
  output logic         serial_valid,
  output logic         busy,
  output logic         done
);

  localparam int BW = $clog2(W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);
  localparam logic [3:0]    LAST_GAP = 4'(GAP_TICKS - 1);

  if (W < 2 || W > 8 || GAP_TICKS < 0 || GAP_TICKS > 15 || SEED == 8'h00) begin : g_param_err
    $error("lane_serializer: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t          state_q,  state_d;
  logic [W-1:0]    shreg_q,  shreg_d;
  logic            dir_q,    dir_d;
  logic [BW-1:0]   bitcnt_q, bitcnt_d;
  logic [3:0]      gapcnt_q, gapcnt_d;
  logic            serial_q, serial_d;
  logic            done_q,   done_d;
  logic            sv_q;

`ifdef LFSR_AUTO_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       lfsr_fb;
  // x^8 + x^6 + x^5 + x^4 + 1
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
`endif

  assign pat_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign serial       = serial_q;
  assign serial_valid = sv_q;
  assign done         = done_q;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    dir_d    = dir_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    serial_d = serial_q;
    done_d   = 1'b0;
`ifdef LFSR_AUTO_EN
    lfsr_d   = lfsr_q;
`endif
    if (abort) begin
      state_d  = IDLE;
      shreg_d  = '0;
      bitcnt_d = '0;
      gapcnt_d = '0;
      serial_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick) serial_d = 1'b0;
          if (pat_valid) begin
            shreg_d  = pat_data;
            dir_d    = dir;
            bitcnt_d = '0;
            state_d  = SHIFT;
          end
`ifdef LFSR_AUTO_EN
          else if (tick) begin
            shreg_d  = lfsr_q[W-1:0];
            dir_d    = dir;
            bitcnt_d = '0;
            lfsr_d   = {lfsr_q[6:0], lfsr_fb};
            state_d  = SHIFT;
          end
`endif
        end
        SHIFT: begin
          if (tick) begin
            serial_d = dir_q ? shreg_q[W-1] : shreg_q[0];
            shreg_d  = dir_q ? {shreg_q[W-2:0], 1'b0} : {1'b0, shreg_q[W-1:1]};
            bitcnt_d = bitcnt_q + 1'b1;
            if (bitcnt_q == LAST_BIT) begin
              if (GAP_TICKS > 0) begin
                gapcnt_d = '0;
                state_d  = GAP;
              end else begin
                state_d  = IDLE;
                done_d   = 1'b1;
              end
            end
          end
        end
        GAP: begin
          if (tick) begin
            serial_d = 1'b0;
            gapcnt_d = gapcnt_q + 1'b1;
            if (gapcnt_q == LAST_GAP) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      dir_q    <= 1'b0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      serial_q <= 1'b0;
      done_q   <= 1'b0;
      sv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      dir_q    <= dir_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      serial_q <= serial_d;
      done_q   <= done_d;
      sv_q     <= tick;
    end
  end

`ifdef LFSR_AUTO_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end
`endif

endmodule

// File: tb/tb_lane_serializer.sv
// Self-checking bench for lane_serializer: vector table of frames plus hand sequences,
// with a scoreboard queue of expected {serial, done} per driven tick.
module tb_lane_serializer;
  localparam int W = 5;
  localparam int G = 2;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         tick, abort, dir, pat_valid;
  logic [W-1:0] pat_data;
  logic         pat_ready, serial, serial_valid, busy, done;

  int checks = 0;
  int errors = 0;
  logic [1:0] q[$];

  lane_serializer #(.W(W), .GAP_TICKS(G), .SEED(8'hA5)) dut (
    .clk(clk), .clr_n(clr_n), .tick(tick), .abort(abort), .dir(dir),
    .pat_valid(pat_valid), .pat_data(pat_data), .pat_ready(pat_ready),
    .serial(serial), .serial_valid(serial_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   pat;
    logic           dr;
    logic           same;
    int             idle;
    logic [W+G-1:0] exp;   // bit i = i-th serial bit after the frame starts
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic t, input logic v, input logic a,
                      input logic [W-1:0] d, input logic dr);
    @(posedge clk); #1;
    tick = t; pat_valid = v; abort = a; pat_data = d; dir = dr;
  endtask

  task automatic push(input logic s, input logic dn);
    q.push_back({s, dn});
  endtask

  task automatic run_frame(input vec_t v);
    if (v.same) begin
      step(1, 1, 0, v.pat, v.dr);
      push(1'b0, 1'b0);
    end else begin
      step(0, 1, 0, v.pat, v.dr);
    end
    for (int i = 0; i < W + G; i++) begin
      for (int k = 0; k < v.idle; k++) step(0, 0, 0, W'($urandom), 1'b0);
      step(1, 0, 0, W'($urandom), ~v.dr);
      push(v.exp[i], (i == W + G - 1));
      if (i == 0) begin
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
        chk("ready_in_frame", {31'd0, pat_ready}, 32'd0);
      end
    end
    step(0, 0, 0, '0, 1'b0);
    chk("ready_after_done", {31'd0, pat_ready}, 32'd1);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  // Scoreboard: every serial_valid pulse consumes one expected {serial, done}.
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (clr_n) begin
        if (serial_valid) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_valid: serial_valid=1 with no expected entry at %0t", $time);
          end else begin
            e = q.pop_front();
            chk("serial_bit", {31'd0, serial}, {31'd0, e[1]});
            chk("done_pulse", {31'd0, done}, {31'd0, e[0]});
          end
        end else if (done) begin
          checks++; errors++;
          $display("FAIL stray_done: done=1 without tick at %0t", $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{5'b10011, 1'b0, 1'b0, 0, 7'b0010011};
    vecs[1] = '{5'b10011, 1'b1, 1'b0, 0, 7'b0011001};
    vecs[2] = '{5'b00001, 1'b0, 1'b1, 0, 7'b0000001};
    vecs[3] = '{5'b01101, 1'b1, 1'b0, 2, 7'b0010110};
    vecs[4] = '{5'b11111, 1'b0, 1'b1, 1, 7'b0011111};

    clr_n = 1'b0; tick = 0; abort = 0; dir = 0; pat_valid = 0; pat_data = '0;
    #3;
    chk("rst_serial", {31'd0, serial}, 32'd0);
    chk("rst_sv", {31'd0, serial_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, pat_ready}, 32'd1);
    @(posedge clk); #1 clr_n = 1'b1;

`ifdef LFSR_AUTO_EN
    begin
      logic [W+G-1:0] lexp[2];
      lexp[0] = 7'b0000101;   // SEED low bits 00101, LSB first
      lexp[1] = 7'b0001010;   // after one LFSR step: 8'h4A
      for (int f = 0; f < 2; f++) begin
        step(1, 0, 0, '0, 1'b0);
        push(1'b0, 1'b0);
        for (int i = 0; i < W + G; i++) begin
          step(1, 0, 0, '0, 1'b0);
          push(lexp[f][i], (i == W + G - 1));
        end
        step(0, 0, 0, '0, 1'b0);
        chk("lfsr_ready_after", {31'd0, pat_ready}, 32'd1);
      end
    end
`else
    step(1, 0, 0, '0, 1'b0);
    push(1'b0, 1'b0);
    step(0, 0, 0, '0, 1'b0);
    chk("idle_tick_ready", {31'd0, pat_ready}, 32'd1);
`endif

    for (int n = 0; n < 5; n++) run_frame(vecs[n]);

    // abort with pat_valid in IDLE must block the accept
    step(0, 1, 1, 5'b10101, 1'b0);
    step(0, 0, 0, '0, 1'b0);
    chk("abort_blocks_accept", {31'd0, pat_ready}, 32'd1);

    // abort after three data bits of 11111
    step(0, 1, 0, 5'b11111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, '0, 1'b0);
      push(1'b1, 1'b0);
    end
    step(0, 0, 1, '0, 1'b0);
    step(0, 0, 0, '0, 1'b0);
    chk("abort_serial", {31'd0, serial}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {31'd0, pat_ready}, 32'd1);
    run_frame('{5'b00110, 1'b0, 1'b0, 0, 7'b0000110});

    // asynchronous reset in the middle of SHIFT
    step(0, 1, 0, 5'b10011, 1'b0);
    step(1, 0, 0, '0, 1'b0); push(1'b1, 1'b0);
    step(1, 0, 0, '0, 1'b0); push(1'b1, 1'b0);
    step(0, 0, 0, '0, 1'b0);
    chk("midframe_busy", {31'd0, busy}, 32'd1);
    #6 clr_n = 1'b0;
    #1;
    chk("async_rst_serial", {31'd0, serial}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_ready", {31'd0, pat_ready}, 32'd1);
    @(posedge clk); #1 clr_n = 1'b1;

    repeat (4) step(0, 0, 0, '0, 1'b0);
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
